// File: rtl/dotled_axil_slave_regs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dotled_axil_slave_regs
// Brief    : AXI4-Lite responder holding four 32-bit control registers for
//            the true-color dot-LED core. Independent write and read paths
//            with full valid/ready back-pressure; exports register contents
//            and a one-cycle write pulse per register.
// Revision : 1.0 - initial release
// ============================================================================
module dotled_axil_slave_regs #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 4,
    parameter logic [DATA_W-1:0]  RESET_VAL = 32'h0000_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,

    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,

    input  logic [DATA_W-1:0]     S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,

    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,

    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,

    output logic [DATA_W-1:0]     S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,

    output logic [4*DATA_W-1:0]   regs_out,
    output logic [3:0]            wr_pulse
);

    localparam int         c_NREGS  = 4;
    localparam int         c_NBYTES = DATA_W / 8;
    localparam logic [1:0] c_OKAY   = 2'b00;

    // Register file and write-path holding state
    logic [DATA_W-1:0]   r_regs [c_NREGS];
    logic                r_aw_held;
    logic [1:0]          r_aw_addr;
    logic                r_w_held;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_NBYTES-1:0] r_wstrb;
    logic                r_bvalid;
    logic [3:0]          r_wr_pulse;

    // Read-path state
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_awready;
    logic                w_wready;
    logic                w_arready;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic                w_commit;
    logic [1:0]          w_widx;
    logic [DATA_W-1:0]   w_wdata;
    logic [c_NBYTES-1:0] w_wstrb;
    logic                w_unused;

    // Readies are forced low while reset is asserted so nothing is accepted
    // into state that is being cleared on the same edge.
    assign w_awready = !ARESET && !r_aw_held && !r_bvalid;
    assign w_wready  = !ARESET && !r_w_held  && !r_bvalid;
    assign w_arready = !ARESET && !r_rvalid;

    assign w_aw_hs   = S_AXI_AWVALID && w_awready;
    assign w_w_hs    = S_AXI_WVALID  && w_wready;
    assign w_ar_hs   = S_AXI_ARVALID && w_arready;

    // A write commits as soon as both halves are present, whether each was
    // latched earlier or is handshaking on this edge.
    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_widx    = r_aw_held ? r_aw_addr : S_AXI_AWADDR[3:2];
    assign w_wdata   = r_w_held  ? r_wdata   : S_AXI_WDATA;
    assign w_wstrb   = r_w_held  ? r_wstrb   : S_AXI_WSTRB;

    // Protection bits and the byte/upper address bits carry no meaning here.
    assign w_unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    // Latch write address/data independently and track the write response
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_held  <= 1'b0;
            r_aw_addr  <= 2'd0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_addr <= S_AXI_AWADDR[3:2];
            end
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                end
                if (r_bvalid && S_AXI_BREADY) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    // Byte-masked register update on the commit edge
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < c_NREGS; k++) begin
                r_regs[k] <= RESET_VAL;
            end
        end else if (w_commit) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (w_wstrb[b]) begin
                    r_regs[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // One-cycle pulse on the register just written, aligned with BVALID rising
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_pulse <= 4'd0;
        end else begin
            r_wr_pulse <= 4'd0;
            if (w_commit) begin
                r_wr_pulse[w_widx] <= 1'b1;
            end
        end
    end

    // Read channel: capture the pre-write register value on the AR handshake
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rdata  <= r_regs[S_AXI_ARADDR[3:2]];
            r_rvalid <= 1'b1;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    generate
        for (genvar g = 0; g < c_NREGS; g++) begin : g_regs_out
            assign regs_out[DATA_W*g +: DATA_W] = r_regs[g];
        end
    endgenerate

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BRESP   = c_OKAY;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = c_OKAY;
    assign S_AXI_RVALID  = r_rvalid;
    assign wr_pulse      = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_dotled_axil_slave_regs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dotled_axil_slave_regs
// Brief    : Self-checking bench for dotled_axil_slave_regs. A transaction-level
//            model (queues of accepted AW/W beats, register array) predicts all
//            outputs every cycle; directed tests add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dotled_axil_slave_regs;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic         tb_ACLK = 1'b0;
    logic         ARESET;
    logic [3:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [3:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] regs_out;
    logic [3:0]   wr_pulse;

    always #5 tb_ACLK = ~tb_ACLK;

    dotled_axil_slave_regs #(
        .DATA_W    (32),
        .ADDR_W    (4),
        .RESET_VAL (RV)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .regs_out      (regs_out),
        .wr_pulse      (wr_pulse)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------
    logic [31:0] m_regs [4];
    logic [1:0]  aw_q [$];
    logic [35:0] w_q [$];
    bit          m_live = 1'b0;
    bit          m_bvalid, m_rvalid;
    logic [31:0] m_rdata;
    logic [3:0]  m_pulse;

    initial begin : p_model
        logic [1:0]  a;
        logic [35:0] wd;
        logic [31:0] mask;
        bit          awr, wr, arr;
        m_bvalid = 0; m_rvalid = 0; m_rdata = '0; m_pulse = '0;
        forever begin
            @(posedge tb_ACLK);
            if (ARESET) begin
                for (int k = 0; k < 4; k++) m_regs[k] = RV;
                aw_q.delete(); w_q.delete();
                m_bvalid = 0; m_rvalid = 0; m_rdata = '0; m_pulse = '0;
                m_live = 1;
            end else if (m_live) begin
                awr = (aw_q.size() == 0) && !m_bvalid;
                wr  = (w_q.size() == 0) && !m_bvalid;
                arr = !m_rvalid;
                m_pulse = '0;
                if (m_rvalid && S_AXI_RREADY) m_rvalid = 0;
                else if (S_AXI_ARVALID && arr) begin
                    m_rdata  = m_regs[S_AXI_ARADDR[3:2]];
                    m_rvalid = 1;
                end
                if (m_bvalid && S_AXI_BREADY) m_bvalid = 0;
                if (S_AXI_AWVALID && awr) aw_q.push_back(S_AXI_AWADDR[3:2]);
                if (S_AXI_WVALID && wr)   w_q.push_back({S_AXI_WSTRB, S_AXI_WDATA});
                if (aw_q.size() > 0 && w_q.size() > 0) begin
                    a    = aw_q.pop_front();
                    wd   = w_q.pop_front();
                    mask = {{8{wd[35]}}, {8{wd[34]}}, {8{wd[33]}}, {8{wd[32]}}};
                    m_regs[a] = (m_regs[a] & ~mask) | (wd[31:0] & mask);
                    m_bvalid  = 1;
                    m_pulse[a] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison, sampled just before the inputs change
    initial begin : p_compare
        forever begin
            @(posedge tb_ACLK);
            #4;
            if (m_live) begin
                chk("awready", S_AXI_AWREADY, !ARESET && aw_q.size() == 0 && !m_bvalid);
                chk("wready",  S_AXI_WREADY,  !ARESET && w_q.size() == 0 && !m_bvalid);
                chk("arready", S_AXI_ARREADY, !ARESET && !m_rvalid);
                chk("bvalid",  S_AXI_BVALID,  m_bvalid);
                chk("bresp",   S_AXI_BRESP,   2'b00);
                chk("rvalid",  S_AXI_RVALID,  m_rvalid);
                chk("rdata",   S_AXI_RDATA,   m_rdata);
                chk("rresp",   S_AXI_RRESP,   2'b00);
                chk("regs_out", regs_out, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
                chk("wr_pulse", wr_pulse, m_pulse);
                for (int k = 0; k < 4; k++)
                    if (wr_pulse[k] === 1'b1) pulse_cnt[k]++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers (all start and end on a falling edge)
    // ------------------------------------------------------------------
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done = 0, w_done = 0;
        int c = 0;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        while (!(aw_done && w_done) && c < 50) begin
            S_AXI_AWVALID = !aw_done && (c >= aw_dly);
            S_AXI_WVALID  = !w_done  && (c >= w_dly);
            #1;
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
            if (S_AXI_WVALID  && S_AXI_WREADY)  w_done  = 1;
            @(negedge tb_ACLK);
            c++;
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        chk("aw_w_timeout", aw_done && w_done, 1'b1);
    endtask

    task automatic wait_b();
        bit done = 0;
        int c = 0;
        while (!done && c < 50) begin
            #1;
            if (S_AXI_BVALID && S_AXI_BREADY) done = 1;
            @(negedge tb_ACLK);
            c++;
        end
        chk("b_timeout", done, 1'b1);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        bit done = 0;
        int c = 0;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1;
        while (!done && c < 50) begin
            #1;
            if (S_AXI_ARREADY) done = 1;
            @(negedge tb_ACLK);
            c++;
        end
        S_AXI_ARVALID = 0;
        chk("ar_timeout", done, 1'b1);
        done = 0; c = 0; data = 'x;
        while (!done && c < 50) begin
            #1;
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                done = 1;
                data = S_AXI_RDATA;
            end
            @(negedge tb_ACLK);
            c++;
        end
        chk("r_timeout", done, 1'b1);
    endtask

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin : p_main
        logic [31:0] d;
        ARESET = 1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0;
        S_AXI_BREADY = 1;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0;
        S_AXI_RREADY = 1;
        for (int k = 0; k < 4; k++) pulse_cnt[k] = 0;

        repeat (3) @(negedge tb_ACLK);
        #1;
        chk("rst_regs",    regs_out, {4{RV}});
        chk("rst_bvalid",  S_AXI_BVALID, 1'b0);
        chk("rst_rvalid",  S_AXI_RVALID, 1'b0);
        chk("rst_rdata",   S_AXI_RDATA, 32'h0);
        chk("rst_awready", S_AXI_AWREADY, 1'b0);
        chk("rst_arready", S_AXI_ARREADY, 1'b0);
        @(negedge tb_ACLK);
        ARESET = 0;
        #1;
        chk("post_rst_awready", S_AXI_AWREADY, 1'b1);
        chk("post_rst_wready",  S_AXI_WREADY,  1'b1);
        chk("post_rst_arready", S_AXI_ARREADY, 1'b1);
        @(negedge tb_ACLK);

        // Fill all four registers and read them back
        axi_write(4'h0, 32'h0101FFFF, 4'hF, 0, 0); wait_b();
        axi_write(4'h4, 32'hABCD0001, 4'hF, 0, 0); wait_b();
        axi_write(4'h8, 32'hDEAD0011, 4'hF, 0, 0); wait_b();
        axi_write(4'hC, 32'hBEEF0011, 4'hF, 0, 0); wait_b();
        axi_read(4'h0, d); chk("rd_reg0", d, 32'h0101FFFF);
        axi_read(4'h4, d); chk("rd_reg1", d, 32'hABCD0001);
        axi_read(4'h8, d); chk("rd_reg2", d, 32'hDEAD0011);
        axi_read(4'hC, d); chk("rd_reg3", d, 32'hBEEF0011);
        for (int k = 0; k < 4; k++) chk("pulse_once", pulse_cnt[k], 1);

        // W three cycles before AW, then AW three cycles before W
        axi_write(4'h4, 32'h13572468, 4'hF, 3, 0);
        #1; chk("w_first_bvalid", S_AXI_BVALID, 1'b1);
        wait_b();
        axi_read(4'h4, d); chk("rd_w_first", d, 32'h13572468);
        axi_write(4'h4, 32'hABCD0001, 4'hF, 0, 3);
        #1; chk("aw_first_bvalid", S_AXI_BVALID, 1'b1);
        wait_b();
        axi_read(4'h4, d); chk("rd_aw_first", d, 32'hABCD0001);

        // Partial strobes, zero strobe, ignored byte-offset bits
        axi_write(4'h8, 32'h12345678, 4'b0101, 0, 0); wait_b();
        axi_read(4'h8, d); chk("rd_strb", d, 32'hDE340078);
        axi_write(4'hC, 32'hFFFFFFFF, 4'b0000, 0, 0); wait_b();
        axi_read(4'hE, d); chk("rd_strb0", d, 32'hBEEF0011);

        // B back-pressure: second write must wait for the B handshake
        S_AXI_BREADY = 0;
        axi_write(4'h0, 32'hCAFE0000, 4'hF, 0, 0);
        fork
            axi_write(4'h8, 32'h0BADF00D, 4'hF, 0, 0);
            begin
                repeat (5) begin
                    #1;
                    chk("bp_bvalid",  S_AXI_BVALID,  1'b1);
                    chk("bp_awready", S_AXI_AWREADY, 1'b0);
                    chk("bp_wready",  S_AXI_WREADY,  1'b0);
                    @(negedge tb_ACLK);
                end
                S_AXI_BREADY = 1;
            end
        join
        wait_b();
        axi_read(4'h0, d); chk("rd_bp0", d, 32'hCAFE0000);
        axi_read(4'h8, d); chk("rd_bp2", d, 32'h0BADF00D);

        // R back-pressure: RDATA held stable
        S_AXI_RREADY = 0;
        fork
            axi_read(4'h0, d);
            begin
                @(negedge tb_ACLK);
                repeat (5) begin
                    #1;
                    chk("bp_rvalid",  S_AXI_RVALID,  1'b1);
                    chk("bp_rdata",   S_AXI_RDATA,   32'hCAFE0000);
                    chk("bp_arready", S_AXI_ARREADY, 1'b0);
                    @(negedge tb_ACLK);
                end
                S_AXI_RREADY = 1;
            end
        join
        chk("rd_rbp", d, 32'hCAFE0000);

        // Same-edge read and write of reg 1
        fork
            begin
                axi_write(4'h4, 32'h55AA55AA, 4'hF, 0, 0);
                wait_b();
            end
            axi_read(4'h4, d);
        join
        chk("rd_same_edge_old", d, 32'hABCD0001);
        axi_read(4'h4, d); chk("rd_same_edge_new", d, 32'h55AA55AA);

        // Reset while a write response is pending
        S_AXI_BREADY = 0;
        axi_write(4'hC, 32'h77777777, 4'hF, 0, 0);
        #1; chk("pre_rst_bvalid", S_AXI_BVALID, 1'b1);
        @(negedge tb_ACLK);
        ARESET = 1;
        @(negedge tb_ACLK);
        #1;
        chk("rst2_bvalid", S_AXI_BVALID, 1'b0);
        chk("rst2_regs",   regs_out, {4{RV}});
        @(negedge tb_ACLK);
        ARESET = 0;
        S_AXI_BREADY = 1;
        #1;
        chk("rst2_awready", S_AXI_AWREADY, 1'b1);
        chk("rst2_wready",  S_AXI_WREADY,  1'b1);
        chk("rst2_arready", S_AXI_ARREADY, 1'b1);
        @(negedge tb_ACLK);

        // Reset with only the address half held: it must be discarded
        S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1;
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 0;
        ARESET = 1;
        @(negedge tb_ACLK);
        ARESET = 0;
        @(negedge tb_ACLK);
        axi_write(4'h8, 32'h31415926, 4'hF, 0, 0); wait_b();
        axi_read(4'h8, d); chk("rd_after_abandon", d, 32'h31415926);
        axi_read(4'h4, d); chk("rd_abandoned_reg", d, RV);

        @(negedge tb_ACLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
